fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first instruction address after reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0080, redirect address on exception.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_stall  in  1  downstream holds the presented instruction.
REQ-006 i_exc  in  1  exception redirect to EXC_VECTOR.
REQ-007 i_eret  in  1  return redirect to i_epc.
REQ-008 i_epc  in  32  exception-return target.
REQ-009 i_jump  in  1  and  i_jump_target  in  32  jump redirect.
REQ-010 i_branch_taken  in  1  and  i_branch_target  in  32  branch redirect.
REQ-011 o_imem_req  out  1  and  o_imem_addr  out  32  instruction memory request.
REQ-012 i_imem_ack  in  1  and  i_imem_rdata  in  32  memory response, valid when ack=1.
REQ-013 o_valid  out  1  instruction outputs valid.
REQ-014 o_instr  out  32;  o_pc  out  32;  o_pc_plus4  out  32.
REQ-015 o_opcode  out  6 (instr[31:26]);  o_Rs  out  5 ([25:21]);  o_Rt  out  5 ([20:16]);  o_Rd  out  5 ([15:11]);  o_funct  out  6 ([5:0]);  o_imm  out  16 ([15:0]); all sliced from o_instr.
REQ-016 o_fault  out  1  presented PC is misaligned.

Function
REQ-017 FSM states IDLE, FETCH, HOLD; encoding free.
REQ-018 IDLE -> FETCH unconditionally on the next edge.
REQ-019 FETCH: o_imem_req=1, o_imem_addr=pc; o_imem_addr held constant until the ack cycle.
REQ-020 FETCH with i_imem_ack=1 and no pending kill: o_instr<=i_imem_rdata, o_pc<=pc, o_valid<=1, state -> HOLD.
REQ-021 HOLD with i_stall=1: all outputs held stable, o_imem_req=0.
REQ-022 HOLD with i_stall=0: o_valid<=0, pc<=next_pc, state -> FETCH.
REQ-023 next_pc priority: i_exc > i_eret > i_jump > i_branch_taken > pending redirect > pc+4; 32-bit wrap, 32'hFFFF_FFFC+4 = 0.
REQ-024 Redirect in HOLD with i_stall=1, or in IDLE: target latched as pending; applied at next pc update; newer redirect overwrites older.
REQ-025 Redirect in FETCH: target latched as pending, kill flag set; request and address unchanged until ack; acked data discarded (o_valid stays 0); on that ack edge pc<=pending target, kill and pending cleared, state stays FETCH.
REQ-026 Redirect in the ack cycle of FETCH behaves as REQ-025 (data discarded).
REQ-027 next_pc[1:0]!=0: no memory request; state -> HOLD next edge with o_valid=1, o_fault=1, o_instr=0, o_pc=misaligned address.
REQ-028 o_pc_plus4 = o_pc + 4, modulo 2^32.
REQ-029 Minimum throughput one instruction per two cycles (zero-wait memory); fetch latency request-to-o_valid = ack cycle + 1.

Reset
REQ-030 While i_rst_n=0: state IDLE, pc=RESET_PC, o_valid=0, o_fault=0, o_imem_req=0, o_instr=0, o_pc=0, pending and kill cleared.
REQ-031 Reset asserted mid-FETCH drops the request immediately; late ack after reset release while in IDLE is ignored.

Verification
REQ-032 Reset release, zero-wait memory returning addr-derived data -> o_imem_addr 0,4,8 in successive FETCH cycles; o_valid high every second cycle; o_pc 0,4,8.
REQ-033 Memory ack delayed 3 cycles -> o_imem_addr stable for 4 cycles, o_valid asserted the cycle after ack.
REQ-034 i_stall high 5 cycles in HOLD -> o_instr/o_pc unchanged, no request; release -> fetch of o_pc+4.
REQ-035 i_jump_target=32'h100 during FETCH of 0x8 with ack 2 cycles later -> 0x8 data discarded, next request 0x100, o_pc=0x100.
REQ-036 i_exc and i_branch_taken same cycle -> next fetch at EXC_VECTOR; i_eret with i_epc=32'h102 -> o_fault=1, o_instr=0, o_pc=0x102, no memory request.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: IDLE/FETCH/HOLD sequencer with prioritised redirects,
// kill of in-flight fetches, misalignment faults and decoded field outputs.
module fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_exc,
  input  logic        i_eret,
  input  logic [31:0] i_epc,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_Rs,
  output logic [4:0]  o_Rt,
  output logic [4:0]  o_Rd,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm,
  output logic        o_fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [31:0] pend_addr;
  logic        pend_valid;
  logic        kill;

  logic        redir;
  logic [31:0] redir_target;
  logic [31:0] next_pc;

  logic        pc_load;
  logic [31:0] pc_val;
  logic        capture;
  logic        fault_set;
  logic        valid_clr;
  logic        pend_set;
  logic        pend_clr;
  logic        kill_set;

  always_comb begin
    redir        = i_exc | i_eret | i_jump | i_branch_taken;
    redir_target = i_branch_target;
    if (i_exc)       redir_target = EXC_VECTOR;
    else if (i_eret) redir_target = i_epc;
    else if (i_jump) redir_target = i_jump_target;
    if (redir)           next_pc = redir_target;
    else if (pend_valid) next_pc = pend_addr;
    else                 next_pc = pc + 32'd4;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pc_load   = 1'b0;
    pc_val    = next_pc;
    capture   = 1'b0;
    fault_set = 1'b0;
    valid_clr = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    kill_set  = 1'b0;
    case (state)
      IDLE: begin
        state_nx = FETCH;
        pend_set = redir;
      end
      FETCH: begin
        if (i_imem_ack) begin
          if (kill || redir) begin
            // Killed fetch: drop the data and refetch at the newest target.
            pc_load  = 1'b1;
            pc_val   = redir ? redir_target : pend_addr;
            pend_clr = 1'b1;
            if (pc_val[1:0] != 2'b00) begin
              fault_set = 1'b1;
              state_nx  = HOLD;
            end
          end else begin
            capture  = 1'b1;
            state_nx = HOLD;
          end
        end else if (redir) begin
          pend_set = 1'b1;
          kill_set = 1'b1;
        end
      end
      HOLD: begin
        if (i_stall) begin
          pend_set = redir;
        end else begin
          pc_load   = 1'b1;
          pend_clr  = 1'b1;
          valid_clr = 1'b1;
          if (next_pc[1:0] != 2'b00) begin
            fault_set = 1'b1;
            state_nx  = HOLD;
          end else begin
            state_nx = FETCH;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc         <= RESET_PC;
      pend_addr  <= '0;
      pend_valid <= 1'b0;
      kill       <= 1'b0;
      o_valid    <= 1'b0;
      o_fault    <= 1'b0;
      o_instr    <= '0;
      o_pc       <= '0;
    end else begin
      if (pc_load) pc <= pc_val;
      if (pend_clr) begin
        pend_valid <= 1'b0;
        kill       <= 1'b0;
      end
      if (pend_set) begin
        pend_valid <= 1'b1;
        pend_addr  <= redir_target;
      end
      if (kill_set) kill <= 1'b1;
      if (valid_clr) begin
        o_valid <= 1'b0;
        o_fault <= 1'b0;
      end
      if (capture) begin
        o_instr <= i_imem_rdata;
        o_pc    <= pc;
        o_valid <= 1'b1;
        o_fault <= 1'b0;
      end
      if (fault_set) begin
        o_instr <= '0;
        o_pc    <= pc_val;
        o_valid <= 1'b1;
        o_fault <= 1'b1;
      end
    end
  end

  assign o_imem_req  = (state == FETCH);
  assign o_imem_addr = pc;
  assign o_pc_plus4  = o_pc + 32'd4;
  assign o_opcode    = o_instr[31:26];
  assign o_Rs        = o_instr[25:21];
  assign o_Rt        = o_instr[20:16];
  assign o_Rd        = o_instr[15:11];
  assign o_funct     = o_instr[5:0];
  assign o_imm       = o_instr[15:0];

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus a randomized run checked against a
// presentation-level model (next presented PC = latest redirect target, else previous + 4).
module tb_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_V  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, exc, eret, jump, branch;
  logic [31:0] epc, jt, bt;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        valid, fault;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Memory responder state
  logic        mem_on = 1'b0;
  logic        mem_rand = 1'b0;
  int unsigned mem_delay = 0;
  int unsigned wait_cnt = 0;
  int unsigned rdly = 0;
  logic        r_ack = 1'b0;
  logic [31:0] r_rdata = '0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;

  assign imem_ack   = mem_on ? r_ack : man_ack;
  assign imem_rdata = mem_on ? r_rdata : man_rdata;

  fetch #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_V)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_exc(exc), .i_eret(eret),
    .i_epc(epc), .i_jump(jump), .i_jump_target(jt), .i_branch_taken(branch),
    .i_branch_target(bt), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata), .o_valid(valid),
    .o_instr(instr), .o_pc(pc), .o_pc_plus4(pc_plus4), .o_opcode(opcode),
    .o_Rs(rs), .o_Rt(rt), .o_Rd(rd), .o_funct(funct), .o_imm(imm), .o_fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if ($urandom_range(0, 7) == 0) t[1:0] = 2'b10;
    return t;
  endfunction

  always @(negedge clk) begin
    if (mem_on) begin
      if (imem_req) begin
        if (wait_cnt >= (mem_rand ? rdly : mem_delay)) begin
          r_ack    = 1'b1;
          r_rdata  = memf(imem_addr);
          wait_cnt = 0;
          rdly     = $urandom_range(0, 3);
        end else begin
          r_ack    = 1'b0;
          r_rdata  = $urandom;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        r_ack    = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic do_reset(input int unsigned dly);
    @(negedge clk);
    rst_n = 1'b0;
    {stall, exc, eret, jump, branch} = '0;
    epc = '0; jt = '0; bt = '0;
    mem_on = 1'b1; mem_rand = 1'b0; mem_delay = dly;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0; mem_on = 1'b0; man_ack = 1'b0; man_rdata = '0;
    {stall, exc, eret, jump, branch} = '0;
    epc = '0; jt = '0; bt = '0;
    repeat (2) @(negedge clk);
    total++; if (valid !== 1'b0) $display("FAIL rst_valid got %0h want 0", valid); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL rst_fault got %0h want 0", fault); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %0h want 0", imem_req); else passed++;
    total++; if (instr !== 32'h0) $display("FAIL rst_instr got %h want 0", instr); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL rst_pc got %h want 0", pc); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if ({imem_req, imem_addr} !== {1'b1, RST_PC}) $display("FAIL first_req got %0h/%h want 1/%h", imem_req, imem_addr, RST_PC); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL async_drop_req got %0h want 0", imem_req); else passed++;
    @(negedge clk);
    rst_n = 1'b1; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    total++; if (valid !== 1'b0) $display("FAIL late_ack_valid got %0h want 0", valid); else passed++;
    @(negedge clk);
    man_ack = 1'b0; mem_delay = 0; mem_on = 1'b1;
    n = 0;
    while (valid !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    total++;
    if (valid !== 1'b1) $display("FAIL late_ack_timeout got valid %0h want 1", valid);
    else if ({pc, instr} !== {RST_PC, memf(RST_PC)}) $display("FAIL late_ack_pres got %h/%h want %h/%h", pc, instr, RST_PC, memf(RST_PC));
    else passed++;
  endtask

  task automatic test_stream;
    logic [31:0] e;
    do_reset(0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      e = 32'(4 * (k / 2));
      if (k % 2 == 0) begin
        total++; if ({imem_req, valid, imem_addr} !== {2'b10, e}) $display("FAIL stream_req%0d got %0h/%0h/%h want 1/0/%h", k, imem_req, valid, imem_addr, e); else passed++;
      end else begin
        total++; if ({valid, imem_req, pc} !== {2'b10, e}) $display("FAIL stream_pres%0d got %0h/%0h/%h want 1/0/%h", k, valid, imem_req, pc, e); else passed++;
        total++; if (instr !== memf(e)) $display("FAIL stream_instr%0d got %h want %h", k, instr, memf(e)); else passed++;
      end
    end
  endtask

  task automatic test_wait_states;
    do_reset(3);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      total++; if ({imem_req, valid, imem_addr} !== {2'b10, 32'h0}) $display("FAIL wait_hold%0d got %0h/%0h/%h want 1/0/0", k, imem_req, valid, imem_addr); else passed++;
    end
    @(posedge clk); #1;
    total++; if ({valid, pc, instr} !== {1'b1, 32'h0, memf(32'h0)}) $display("FAIL wait_pres got %0h/%h/%h want 1/0/%h", valid, pc, instr, memf(32'h0)); else passed++;
  endtask

  task automatic test_stall;
    do_reset(0);
    @(posedge clk);
    @(negedge clk); stall = 1'b1;
    @(posedge clk); #1;
    total++; if ({valid, pc} !== {1'b1, 32'h0}) $display("FAIL stall_first got %0h/%h want 1/0", valid, pc); else passed++;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++; if ({valid, imem_req, pc, instr} !== {2'b10, 32'h0, memf(32'h0)}) $display("FAIL stall_hold%0d got %0h/%0h/%h/%h want 1/0/0/%h", k, valid, imem_req, pc, instr, memf(32'h0)); else passed++;
    end
    @(negedge clk); stall = 1'b0;
    @(posedge clk); #1;
    total++; if ({imem_req, valid, imem_addr} !== {2'b10, 32'h4}) $display("FAIL stall_release got %0h/%0h/%h want 1/0/4", imem_req, valid, imem_addr); else passed++;
    @(posedge clk); #1;
    total++; if ({valid, pc, instr} !== {1'b1, 32'h4, memf(32'h4)}) $display("FAIL stall_next got %0h/%h/%h want 1/4/%h", valid, pc, instr, memf(32'h4)); else passed++;
  endtask

  task automatic test_jump_kill;
    int n;
    do_reset(0);
    repeat (4) @(posedge clk);
    @(negedge clk); mem_delay = 2;
    @(posedge clk); #1;
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) $display("FAIL kill_req8 got %0h/%h want 1/8", imem_req, imem_addr); else passed++;
    @(negedge clk); jump = 1'b1; jt = 32'h100;
    @(posedge clk); #1;
    total++; if ({imem_req, valid, imem_addr} !== {2'b10, 32'h8}) $display("FAIL kill_keep_a got %0h/%0h/%h want 1/0/8", imem_req, valid, imem_addr); else passed++;
    @(negedge clk); jump = 1'b0;
    @(posedge clk); #1;
    total++; if ({imem_req, valid, imem_addr} !== {2'b10, 32'h8}) $display("FAIL kill_keep_b got %0h/%0h/%h want 1/0/8", imem_req, valid, imem_addr); else passed++;
    @(posedge clk); #1;
    total++; if ({imem_req, valid, imem_addr} !== {2'b10, 32'h100}) $display("FAIL kill_discard got %0h/%0h/%h want 1/0/100", imem_req, valid, imem_addr); else passed++;
    n = 0;
    while (valid !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    total++; if ({valid, pc, instr} !== {1'b1, 32'h100, memf(32'h100)}) $display("FAIL kill_target got %0h/%h/%h want 1/100/%h", valid, pc, instr, memf(32'h100)); else passed++;
  endtask

  task automatic test_exc_eret;
    do_reset(0);
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk); exc = 1'b1; branch = 1'b1; bt = 32'h200;
    @(posedge clk); #1;
    total++; if ({imem_req, valid, imem_addr} !== {2'b10, EXC_V}) $display("FAIL exc_prio got %0h/%0h/%h want 1/0/%h", imem_req, valid, imem_addr, EXC_V); else passed++;
    @(negedge clk); exc = 1'b0; branch = 1'b0;
    @(posedge clk); #1;
    total++; if ({valid, pc, instr} !== {1'b1, EXC_V, memf(EXC_V)}) $display("FAIL exc_pres got %0h/%h/%h want 1/%h/%h", valid, pc, instr, EXC_V, memf(EXC_V)); else passed++;
    @(negedge clk); eret = 1'b1; epc = 32'h102;
    @(posedge clk); #1;
    total++; if ({valid, fault, imem_req} !== 3'b110) $display("FAIL eret_fault_flags got %0h/%0h/%0h want 1/1/0", valid, fault, imem_req); else passed++;
    total++; if ({instr, pc, pc_plus4} !== {32'h0, 32'h102, 32'h106}) $display("FAIL eret_fault_data got %h/%h/%h want 0/102/106", instr, pc, pc_plus4); else passed++;
    @(negedge clk); eret = 1'b0; stall = 1'b1;
    @(posedge clk); #1;
    total++; if ({valid, fault, imem_req, pc} !== {3'b110, 32'h102}) $display("FAIL fault_hold got %0h/%0h/%0h/%h want 1/1/0/102", valid, fault, imem_req, pc); else passed++;
    @(negedge clk); stall = 1'b0; jump = 1'b1; jt = 32'h10;
    @(posedge clk); #1;
    total++; if ({valid, fault, imem_req, imem_addr} !== {3'b001, 32'h10}) $display("FAIL fault_recover got %0h/%0h/%0h/%h want 0/0/1/10", valid, fault, imem_req, imem_addr); else passed++;
    @(negedge clk); jump = 1'b0;
  endtask

  task automatic test_wrap;
    do_reset(0);
    @(posedge clk); #1;
    @(negedge clk); jump = 1'b1; jt = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    total++; if ({valid, imem_req, imem_addr} !== {2'b01, 32'hFFFF_FFFC}) $display("FAIL ackcycle_redirect got %0h/%0h/%h want 0/1/fffffffc", valid, imem_req, imem_addr); else passed++;
    @(negedge clk); jump = 1'b0;
    @(posedge clk); #1;
    total++; if ({valid, pc, pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) $display("FAIL wrap_pres got %0h/%h/%h want 1/fffffffc/0", valid, pc, pc_plus4); else passed++;
    total++; if (instr !== memf(32'hFFFF_FFFC)) $display("FAIL wrap_instr got %h want %h", instr, memf(32'hFFFF_FFFC)); else passed++;
    @(posedge clk); #1;
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL wrap_next got %0h/%h want 1/0", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_random;
    logic [31:0] want, paddr, ei;
    logic        pv, pcons, preq, pack, ef;
    int unsigned idle;
    do_reset(0);
    mem_rand = 1'b1;
    want = RST_PC;
    idle = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #1;
      pv = valid; preq = imem_req; paddr = imem_addr; pack = imem_ack;
      stall  = ($urandom_range(0, 9) < 3);
      exc    = (i >= 2) && ($urandom_range(0, 39) == 0);
      eret   = (i >= 2) && ($urandom_range(0, 39) == 0);
      jump   = (i >= 2) && ($urandom_range(0, 39) == 0);
      branch = (i >= 2) && ($urandom_range(0, 39) == 0);
      epc = rand_tgt(); jt = rand_tgt(); bt = rand_tgt();
      pcons = pv && !stall;
      if (exc)         want = EXC_V;
      else if (eret)   want = epc;
      else if (jump)   want = jt;
      else if (branch) want = bt;
      @(posedge clk); #1;
      total++; if (pc_plus4 !== pc + 32'd4) $display("FAIL rnd_plus4 got %h want %h", pc_plus4, pc + 32'd4); else passed++;
      if (valid) begin
        total++; if (imem_req !== 1'b0) $display("FAIL rnd_req_in_hold got %0h want 0", imem_req); else passed++;
      end
      if (preq && !pack) begin
        total++; if ({imem_req, imem_addr} !== {1'b1, paddr}) $display("FAIL rnd_addr_stable got %0h/%h want 1/%h", imem_req, imem_addr, paddr); else passed++;
      end
      if (valid && (!pv || pcons)) begin
        ef = (want[1:0] != 2'b00);
        ei = ef ? 32'h0 : memf(want);
        total++; if ({pc, fault} !== {want, ef}) $display("FAIL rnd_pc got %h/%0h want %h/%0h", pc, fault, want, ef); else passed++;
        total++; if (instr !== ei) $display("FAIL rnd_instr got %h want %h", instr, ei); else passed++;
        total++; if ({opcode, rs, rt, rd, funct, imm} !== {ei[31:26], ei[25:21], ei[20:16], ei[15:11], ei[5:0], ei[15:0]}) $display("FAIL rnd_fields got %h want %h", {opcode, rs, rt, rd, funct, imm}, {ei[31:26], ei[25:21], ei[20:16], ei[15:11], ei[5:0], ei[15:0]}); else passed++;
        want = want + 32'd4;
        idle = 0;
      end else begin
        idle++;
        if (idle > 60) begin
          total++;
          $display("FAIL rnd_timeout got no presentation for %0d cycles want <= 60", idle);
          break;
        end
      end
    end
    {stall, exc, eret, jump, branch} = '0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_wait_states;
    test_stall;
    test_jump_kill;
    test_exc_eret;
    test_wrap;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
